// File: rtl/axon_spike_scheduler.sv
// Per-timestep axon sequencer: snapshots both cores' spike vectors on start,
// then issues every set axon as {core, index}, round-robin between the cores,
// and finishes each timestep with a one-cycle done pulse.
module axon_spike_scheduler #(
    parameter int NUM_AXONS = 256,
    parameter int IDX_W     = 8,
    parameter int TS_W      = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [1:0]           core_en_i,
    input  logic [NUM_AXONS-1:0] spike_axon_0_i,
    input  logic [NUM_AXONS-1:0] spike_axon_1_i,
    output logic                 axon_valid_o,
    input  logic                 axon_ready_i,
    output logic                 axon_core_o,
    output logic [IDX_W-1:0]     axon_idx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [TS_W-1:0]      ts_count_o,
    output logic [IDX_W+1:0]     spike_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [NUM_AXONS-1:0]  snap0_q, snap1_q, snap0_d, snap1_d;
    logic                  last_grant_q, last_grant_d;
    logic                  valid_d, core_d;
    logic [IDX_W-1:0]      idx_d;
    logic [TS_W-1:0]       ts_d;
    logic [IDX_W+1:0]      cnt_d;
    logic                  regrant, any0, any1;
    logic                  xfer;

    // Lowest set bit wins, giving ascending issue order within a core.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_AXONS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_AXONS - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    assign xfer   = axon_valid_o & axon_ready_i;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);

    // Next-state, snapshot update and registered-output selection.
    always_comb begin
        state_d      = state_q;
        snap0_d      = snap0_q;
        snap1_d      = snap1_q;
        last_grant_d = last_grant_q;
        valid_d      = axon_valid_o;
        core_d       = axon_core_o;
        idx_d        = axon_idx_o;
        ts_d         = ts_count_o;
        cnt_d        = spike_count_o;
        regrant      = 1'b0;
        any0         = 1'b0;
        any1         = 1'b0;

        if (abort_i) begin
            // Abort drops the timestep silently; counters keep their values.
            state_d = S_IDLE;
            snap0_d = '0;
            snap1_d = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        snap0_d = spike_axon_0_i & {NUM_AXONS{core_en_i[0]}};
                        snap1_d = spike_axon_1_i & {NUM_AXONS{core_en_i[1]}};
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                        regrant = 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (xfer) begin
                        if (axon_core_o) snap1_d[axon_idx_o] = 1'b0;
                        else             snap0_d[axon_idx_o] = 1'b0;
                        cnt_d   = spike_count_o + (IDX_W+2)'(1);
                        regrant = 1'b1;
                    end else if (!axon_valid_o) begin
                        // Valid is low in ISSUE only once both snapshots are empty.
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    ts_d    = ts_count_o + TS_W'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (regrant) begin
            any0    = |snap0_d;
            any1    = |snap1_d;
            valid_d = any0 | any1;
            if (any0 && any1) core_d = ~last_grant_q;
            else if (any0)    core_d = 1'b0;
            else if (any1)    core_d = 1'b1;
            if (valid_d) begin
                last_grant_d = core_d;
                idx_d        = core_d ? lowest_set(snap1_d) : lowest_set(snap0_d);
            end
        end
    end

    // State, snapshots and all outputs are registered; reset clears everything.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q       <= S_IDLE;
            snap0_q       <= '0;
            snap1_q       <= '0;
            last_grant_q  <= 1'b1;
            axon_valid_o  <= 1'b0;
            axon_core_o   <= 1'b0;
            axon_idx_o    <= '0;
            ts_count_o    <= '0;
            spike_count_o <= '0;
        end else begin
            state_q       <= state_d;
            snap0_q       <= snap0_d;
            snap1_q       <= snap1_d;
            last_grant_q  <= last_grant_d;
            axon_valid_o  <= valid_d;
            axon_core_o   <= core_d;
            axon_idx_o    <= idx_d;
            ts_count_o    <= ts_d;
            spike_count_o <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Directed bench for axon_spike_scheduler: reset, single core, round-robin,
// backpressure, empty timestep, abort and ignored start.
module tb_axon_spike_scheduler;

    localparam int NUM_AXONS = 256;
    localparam int IDX_W     = 8;
    localparam int TS_W      = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start, abort_s, ready;
    logic [1:0]           core_en;
    logic [NUM_AXONS-1:0] v0, v1;
    logic                 valid, core;
    logic [IDX_W-1:0]     idx;
    logic                 busy, done;
    logic [TS_W-1:0]      ts;
    logic [IDX_W+1:0]     cnt;

    int checks = 0;
    int errors = 0;

    axon_spike_scheduler #(.NUM_AXONS(NUM_AXONS), .IDX_W(IDX_W), .TS_W(TS_W)) dut (
        .wb_clk_i       (clk),
        .wb_rst_ni      (rst_n),
        .start_i        (start),
        .abort_i        (abort_s),
        .core_en_i      (core_en),
        .spike_axon_0_i (v0),
        .spike_axon_1_i (v1),
        .axon_valid_o   (valid),
        .axon_ready_i   (ready),
        .axon_core_o    (core),
        .axon_idx_o     (idx),
        .busy_o         (busy),
        .done_o         (done),
        .ts_count_o     (ts),
        .spike_count_o  (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_axon(input string tag, input logic v, input logic c, input int i);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) begin
            chk({tag, ".core"}, 32'(core), 32'(c));
            chk({tag, ".idx"}, 32'(idx), 32'(i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort_s = 1'b0; ready = 1'b0;
        core_en = 2'b00; v0 = '0; v1 = '0;
        step(); step();
        chk("rst.valid", 32'(valid), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.ts", 32'(ts), 0);
        chk("rst.cnt", 32'(cnt), 0);
        chk("rst.idx", 32'(idx), 0);
        rst_n = 1'b1;

        // 1: asynchronous reset in the middle of ISSUE
        core_en = 2'b01; v0 = '0; v0[5] = 1'b1; ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        chk_axon("t1.pre", 1'b1, 1'b0, 5);
        chk("t1.pre.busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1.async.valid", 32'(valid), 0);
        chk("t1.async.busy", 32'(busy), 0);
        chk("t1.async.idx", 32'(idx), 0);
        rst_n = 1'b1;
        step();
        chk("t1.post.busy", 32'(busy), 0);
        chk("t1.post.valid", 32'(valid), 0);
        chk("t1.post.ts", 32'(ts), 0);

        // 2: single core, ready held high
        core_en = 2'b01; v0 = '0; v0[3] = 1'b1; v0[17] = 1'b1; v0[255] = 1'b1;
        v1 = '1; ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        chk_axon("t2.a0", 1'b1, 1'b0, 3);
        chk("t2.busy", 32'(busy), 1);
        step(); chk_axon("t2.a1", 1'b1, 1'b0, 17); chk("t2.cnt1", 32'(cnt), 1);
        step(); chk_axon("t2.a2", 1'b1, 1'b0, 255); chk("t2.cnt2", 32'(cnt), 2);
        step(); chk_axon("t2.empty", 1'b0, 1'b0, 0); chk("t2.nodone", 32'(done), 0);
        chk("t2.cnt3", 32'(cnt), 3);
        step(); chk("t2.done", 32'(done), 1); chk("t2.done.busy", 32'(busy), 1);
        step(); chk("t2.done.off", 32'(done), 0); chk("t2.idle.busy", 32'(busy), 0);
        chk("t2.ts", 32'(ts), 1); chk("t2.cnt", 32'(cnt), 3);

        // 3: round-robin from a fresh reset (core 0 wins first)
        rst_n = 1'b0; #2 rst_n = 1'b1;
        core_en = 2'b11; v0 = '0; v0[1] = 1'b1; v0[2] = 1'b1; v0[3] = 1'b1;
        v1 = '0; v1[5] = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        chk_axon("t3.a0", 1'b1, 1'b0, 1);
        step(); chk_axon("t3.a1", 1'b1, 1'b1, 5);
        step(); chk_axon("t3.a2", 1'b1, 1'b0, 2);
        step(); chk_axon("t3.a3", 1'b1, 1'b0, 3);
        step(); chk_axon("t3.empty", 1'b0, 1'b0, 0); chk("t3.cnt", 32'(cnt), 4);
        step(); chk("t3.done", 32'(done), 1);
        step(); chk("t3.ts", 32'(ts), 1);

        // 4: backpressure on (1,9); core 0 disabled though its vector is full
        core_en = 2'b10; v0 = '1; v1 = '0; v1[9] = 1'b1; ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_axon($sformatf("t4.hold%0d", k), 1'b1, 1'b1, 9);
            if (k < 4) step();
        end
        chk("t4.cnt0", 32'(cnt), 0);
        ready = 1'b1;
        step(); chk_axon("t4.after", 1'b0, 1'b0, 0); chk("t4.cnt1", 32'(cnt), 1);
        step(); chk("t4.done", 32'(done), 1);
        step(); chk("t4.ts", 32'(ts), 2); chk("t4.cnt", 32'(cnt), 1);

        // 5: both cores disabled -> empty timestep
        core_en = 2'b00; v0 = '1; v1 = '1; start = 1'b1;
        step(); start = 1'b0;
        chk_axon("t5.c1", 1'b0, 1'b0, 0); chk("t5.c1.busy", 32'(busy), 1);
        chk("t5.c1.done", 32'(done), 0); chk("t5.cnt", 32'(cnt), 0);
        step(); chk("t5.c2.done", 32'(done), 1); chk_axon("t5.c2", 1'b0, 1'b0, 0);
        step(); chk("t5.c3.done", 32'(done), 0); chk("t5.ts", 32'(ts), 3);

        // 6: start ignored mid-timestep, abort after two transfers, then restart
        core_en = 2'b01; v0 = 256'hf; v1 = '0; ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        chk_axon("t6.a0", 1'b1, 1'b0, 0);
        step(); chk_axon("t6.a1", 1'b1, 1'b0, 1); chk("t6.cnt1", 32'(cnt), 1);
        core_en = 2'b11; v0 = '0; v0[200] = 1'b1; v1 = '1; start = 1'b1;
        step(); start = 1'b0;
        chk_axon("t6.a2", 1'b1, 1'b0, 2); chk("t6.cnt2", 32'(cnt), 2);
        abort_s = 1'b1;
        step(); abort_s = 1'b0;
        chk_axon("t6.abort", 1'b0, 1'b0, 0); chk("t6.abort.busy", 32'(busy), 0);
        chk("t6.abort.done", 32'(done), 0); chk("t6.abort.cnt", 32'(cnt), 2);
        chk("t6.abort.ts", 32'(ts), 3);
        step(); chk("t6.idle.done", 32'(done), 0); chk("t6.idle.valid", 32'(valid), 0);
        core_en = 2'b01; v0 = '0; v0[4] = 1'b1; v1 = '0; start = 1'b1;
        step(); start = 1'b0;
        chk_axon("t6.r0", 1'b1, 1'b0, 4); chk("t6.r.cnt0", 32'(cnt), 0);
        step(); chk_axon("t6.r.empty", 1'b0, 1'b0, 0); chk("t6.r.cnt1", 32'(cnt), 1);
        step(); chk("t6.r.done", 32'(done), 1);
        step(); chk("t6.r.ts", 32'(ts), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
